// File: rtl/serial_subtractor.sv
// Bit-serial N-bit subtractor: D = A - B - bin, LSB first, one bit per clock.
// A single full-subtractor cell and a borrow flop, sequenced by a small FSM.
module serial_subtractor #(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         bin,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] d,
   output logic         bout,
   output logic         ovf
);

   localparam int CW = $clog2(N);
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t         state;
   state_t         next_state;
   logic [N-1:0]   a_reg;
   logic [N-1:0]   b_reg;
   logic [N-1:0]   res_reg;
   logic [N-1:0]   res_next;
   logic [CW-1:0]  cnt;
   logic           borrow;
   logic           borrow_next;
   logic           diff;
   logic           a_msb;
   logic           b_msb;
   logic           accept;
   logic           last;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= next_state;
   end

   always_comb begin
      next_state = state;
      accept     = 1'b0;
      last       = (cnt == LAST);
      case (state)
         IDLE: begin
            if (start) begin
               accept     = 1'b1;
               next_state = SHIFT;
            end
         end
         SHIFT: begin
            if (last) next_state = DONE;
         end
         DONE: begin
            // A request in the done cycle starts the next operation with no gap.
            if (start) begin
               accept     = 1'b1;
               next_state = SHIFT;
            end else begin
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      diff        = a_reg[0] ^ b_reg[0] ^ borrow;
      borrow_next = (~a_reg[0] & b_reg[0]) | (~(a_reg[0] ^ b_reg[0]) & borrow);
      res_next    = {diff, res_reg[N-1:1]};
   end

   // Operand MSBs are kept separately because the operand registers shift them away.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_reg   <= '0;
         b_reg   <= '0;
         res_reg <= '0;
         cnt     <= '0;
         borrow  <= 1'b0;
         a_msb   <= 1'b0;
         b_msb   <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         d       <= '0;
         bout    <= 1'b0;
         ovf     <= 1'b0;
      end else if (accept) begin
         a_reg   <= a;
         b_reg   <= b;
         res_reg <= '0;
         cnt     <= '0;
         borrow  <= bin;
         a_msb   <= a[N-1];
         b_msb   <= b[N-1];
         busy    <= 1'b1;
         done    <= 1'b0;
      end else if (state == SHIFT) begin
         a_reg   <= a_reg >> 1;
         b_reg   <= b_reg >> 1;
         res_reg <= res_next;
         borrow  <= borrow_next;
         cnt     <= cnt + CW'(1);
         done    <= 1'b0;
         if (last) begin
            d    <= res_next;
            bout <= borrow_next;
            ovf  <= (a_msb != b_msb) && (res_next[N-1] != a_msb);
            busy <= 1'b0;
            done <= 1'b1;
         end
      end else begin
         done <= 1'b0;
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (N=8), sampling on the falling edge.
module tb_serial_subtractor;

   localparam int N = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [N-1:0] a = '0;
   logic [N-1:0] b = '0;
   logic         bin = 1'b0;
   logic         busy;
   logic         done;
   logic [N-1:0] d;
   logic         bout;
   logic         ovf;

   int           checks = 0;
   int           failures = 0;
   logic [N-1:0] last_d = '0;
   int           bc;
   bit           got;
   int           gap;

   serial_subtractor #(.N(N)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .bin   (bin),
      .busy  (busy),
      .done  (done),
      .d     (d),
      .bout  (bout),
      .ovf   (ovf)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Drives one start pulse across a single rising edge; returns just after it.
   task automatic launch(input logic [N-1:0] av, input logic [N-1:0] bv, input logic bv_in);
      @(negedge clk);
      a     = av;
      b     = bv;
      bin   = bv_in;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Waits (bounded) for done, counting busy cycles and checking that d holds mid-shift.
   task automatic wait_done(input string tag, input bit hold, output int busy_cycles, output bit seen);
      busy_cycles = 0;
      seen        = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (done === 1'b1) begin
            seen = 1'b1;
            break;
         end
         if (busy === 1'b1) begin
            busy_cycles++;
            if (hold && busy_cycles == 4) check({tag, "_d_hold"}, 32'(d), 32'(last_d));
         end
         @(negedge clk);
      end
   endtask

   task automatic do_op(input string tag, input logic [N-1:0] av, input logic [N-1:0] bv,
                        input logic bv_in, input logic [N-1:0] exp_d, input logic exp_bout,
                        input logic exp_ovf);
      int  cycles;
      bit  seen;
      launch(av, bv, bv_in);
      check({tag, "_busy_rise"}, 32'(busy), 32'd1);
      wait_done(tag, 1'b1, cycles, seen);
      check({tag, "_done_seen"}, 32'(seen), 32'd1);
      check({tag, "_busy_cycles"}, 32'(cycles), 32'd8);
      check({tag, "_d"}, 32'(d), 32'(exp_d));
      check({tag, "_bout"}, 32'(bout), 32'(exp_bout));
      check({tag, "_ovf"}, 32'(ovf), 32'(exp_ovf));
      last_d = exp_d;
      @(negedge clk);
      check({tag, "_done_pulse"}, 32'(done), 32'd0);
   endtask

   initial begin
      $display("[TB] serial_subtractor directed test, N=%0d", N);
      #12;
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_done", 32'(done), 32'd0);
      check("reset_d", 32'(d), 32'd0);
      check("reset_bout", 32'(bout), 32'd0);
      check("reset_ovf", 32'(ovf), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      do_op("op_5a_3c", 8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 1'b0);
      do_op("op_3c_5a", 8'h3C, 8'h5A, 1'b0, 8'hE2, 1'b1, 1'b0);
      do_op("op_80_01", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
      do_op("op_7f_ff", 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1);
      do_op("op_00_00_b1", 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0);
      do_op("op_ff_ff", 8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0);

      // Start during shift must be ignored.
      launch(8'h10, 8'h01, 1'b0);
      @(negedge clk);
      @(negedge clk);
      a     = 8'hAA;
      b     = 8'h55;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done("ignore", 1'b0, bc, got);
      check("ignore_done_seen", 32'(got), 32'd1);
      check("ignore_d", 32'(d), 32'h0F);
      check("ignore_bout", 32'(bout), 32'd0);

      // Start held high through DONE chains the next operation with no idle cycle.
      a     = 8'h20;
      b     = 8'h01;
      bin   = 1'b0;
      start = 1'b1;
      gap   = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         gap++;
         if (gap == 1) check("chain_busy_immediate", 32'(busy), 32'd1);
         if (done === 1'b1) break;
      end
      start = 1'b0;
      check("chain_done_spacing", 32'(gap), 32'd9);
      check("chain_d", 32'(d), 32'h1F);
      last_d = 8'h1F;
      @(negedge clk);
      check("chain_idle_busy", 32'(busy), 32'd0);
      check("chain_idle_done", 32'(done), 32'd0);

      // Asynchronous reset mid-shift.
      do_op("pre_reset", 8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 1'b0);
      launch(8'h12, 8'h34, 1'b0);
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_busy", 32'(busy), 32'd0);
      check("async_rst_done", 32'(done), 32'd0);
      check("async_rst_d", 32'(d), 32'd0);
      check("async_rst_bout", 32'(bout), 32'd0);
      check("async_rst_ovf", 32'(ovf), 32'd0);
      @(negedge clk);
      rst_n  = 1'b1;
      last_d = '0;
      do_op("op_05_07", 8'h05, 8'h07, 1'b0, 8'hFE, 1'b1, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
